// File: rtl/float32_pkg.sv
// Shared float32 field constants, slice helpers and the accumulator state encoding.
package float32_pkg;
   localparam logic [7:0] EXP_BIAS = 8'd127;
   localparam logic [7:0] EXP_INF  = 8'd255;
   localparam int         MANT_W   = 23;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ALIGN,
      ST_ADD,
      ST_NORM,
      ST_OUT
   } acc_state_t;

   // Exponent 0 encodes zero, so the hidden bit is only present for nonzero exponents.
   function automatic logic [MANT_W:0] f_mant(input logic [7:0] e, input logic [MANT_W-1:0] frac);
      return (e == 8'd0) ? '0 : {1'b1, frac};
   endfunction

   function automatic logic [7:0] f_bias(input int unbiased);
      return 8'(unbiased + int'(EXP_BIAS));
   endfunction

   function automatic logic [31:0] f_pack(input logic s, input logic [7:0] e, input logic [MANT_W:0] m);
      return {s, e, m[MANT_W-1:0]};
   endfunction
endpackage

// File: rtl/float32_align_add.sv
// Combinational magnitude swap, alignment shift and 25-bit add/subtract of two unpacked floats.
module float32_align_add
   import float32_pkg::*;
(
   input  logic              a_sign,
   input  logic [7:0]        a_exp,
   input  logic [MANT_W:0]   a_mant,
   input  logic              b_sign,
   input  logic [7:0]        b_exp,
   input  logic [MANT_W:0]   b_mant,
   output logic              res_sign,
   output logic [7:0]        res_exp,
   output logic [MANT_W+1:0] res_mant
);
   logic              a_big;
   logic              big_sign, sml_sign;
   logic [7:0]        big_exp, sml_exp, exp_diff;
   logic [MANT_W:0]   big_mant, sml_mant, sml_shifted;
   logic [MANT_W+1:0] sum;

   always_comb begin
      a_big       = (a_exp > b_exp) || ((a_exp == b_exp) && (a_mant >= b_mant));
      big_sign    = a_big ? a_sign : b_sign;
      big_exp     = a_big ? a_exp  : b_exp;
      big_mant    = a_big ? a_mant : b_mant;
      sml_sign    = a_big ? b_sign : a_sign;
      sml_exp     = a_big ? b_exp  : a_exp;
      sml_mant    = a_big ? b_mant : a_mant;
      exp_diff    = big_exp - sml_exp;
      sml_shifted = (exp_diff >= 8'd24) ? '0 : (sml_mant >> exp_diff);
      if (big_sign == sml_sign)
         sum = {1'b0, big_mant} + {1'b0, sml_shifted};
      else
         sum = {1'b0, big_mant} - {1'b0, sml_shifted};
      res_mant = sum;
      res_exp  = big_exp;
      // Exact cancellation always yields +0.
      res_sign = (sum == '0) ? 1'b0 : big_sign;
   end
endmodule

// File: rtl/float32_accumulator.sv
// Multi-cycle float32 running-sum accumulator with valid/ready input and output handshakes.
module float32_accumulator
   import float32_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_overflow
);
   acc_state_t        state_reg;
   logic              acc_sign_reg, acc_inf_reg, last_reg;
   logic [7:0]        acc_exp_reg;
   logic [MANT_W:0]   acc_mant_reg;
   logic              op_sign_reg;
   logic [7:0]        op_exp_reg;
   logic [MANT_W:0]   op_mant_reg;
   logic              sum_sign_reg, norm_first_reg;
   logic [7:0]        sum_exp_reg;
   logic [MANT_W+1:0] sum_mant_reg;
   logic [31:0]       out_data_reg;
   logic              out_valid_reg, out_overflow_reg;

   logic              add_sign;
   logic [7:0]        add_exp;
   logic [MANT_W+1:0] add_mant;

   logic [7:0]        norm_exp_next;
   logic [MANT_W+1:0] norm_mant_next;
   logic              norm_done, norm_zero, norm_ovf;
   logic              wr_sign, wr_inf;
   logic [7:0]        wr_exp;
   logic [MANT_W:0]   wr_mant;

   assign in_ready     = (state_reg == ST_IDLE);
   assign out_data     = out_data_reg;
   assign out_valid    = out_valid_reg;
   assign out_overflow = out_overflow_reg;

   float32_align_add u_align_add (
      .a_sign   (acc_sign_reg),
      .a_exp    (acc_exp_reg),
      .a_mant   (acc_mant_reg),
      .b_sign   (op_sign_reg),
      .b_exp    (op_exp_reg),
      .b_mant   (op_mant_reg),
      .res_sign (add_sign),
      .res_exp  (add_exp),
      .res_mant (add_mant)
   );

   // One normalisation step per NORM cycle: the first cycle handles carry-out and zero,
   // later cycles perform a single left shift each.
   always_comb begin
      norm_mant_next = sum_mant_reg;
      norm_exp_next  = sum_exp_reg;
      norm_done      = 1'b0;
      norm_zero      = 1'b0;
      norm_ovf       = 1'b0;
      if (acc_inf_reg) begin
         norm_done = 1'b1;
      end else if (norm_first_reg) begin
         if (sum_mant_reg == '0) begin
            norm_zero = 1'b1;
            norm_done = 1'b1;
         end else if (sum_mant_reg[MANT_W+1]) begin
            norm_mant_next = sum_mant_reg >> 1;
            norm_exp_next  = sum_exp_reg + 8'd1;
            norm_done      = 1'b1;
            norm_ovf       = (norm_exp_next == EXP_INF);
         end else if (sum_mant_reg[MANT_W]) begin
            norm_done = 1'b1;
         end
      end else begin
         norm_mant_next = sum_mant_reg << 1;
         norm_exp_next  = sum_exp_reg - 8'd1;
         if (norm_exp_next == 8'd0) begin
            norm_zero = 1'b1;
            norm_done = 1'b1;
         end else if (norm_mant_next[MANT_W]) begin
            norm_done = 1'b1;
         end
      end

      wr_sign = acc_sign_reg;
      wr_exp  = acc_exp_reg;
      wr_mant = acc_mant_reg;
      wr_inf  = acc_inf_reg;
      if (!acc_inf_reg) begin
         if (norm_ovf) begin
            wr_sign = sum_sign_reg;
            wr_exp  = EXP_INF;
            wr_mant = '0;
            wr_inf  = 1'b1;
         end else if (norm_zero) begin
            wr_sign = 1'b0;
            wr_exp  = 8'd0;
            wr_mant = '0;
         end else begin
            wr_sign = sum_sign_reg;
            wr_exp  = norm_exp_next;
            wr_mant = norm_mant_next[MANT_W:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= ST_IDLE;
         acc_sign_reg     <= 1'b0;
         acc_exp_reg      <= 8'd0;
         acc_mant_reg     <= '0;
         acc_inf_reg      <= 1'b0;
         last_reg         <= 1'b0;
         op_sign_reg      <= 1'b0;
         op_exp_reg       <= 8'd0;
         op_mant_reg      <= '0;
         sum_sign_reg     <= 1'b0;
         sum_exp_reg      <= 8'd0;
         sum_mant_reg     <= '0;
         norm_first_reg   <= 1'b0;
         out_data_reg     <= 32'd0;
         out_valid_reg    <= 1'b0;
         out_overflow_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: if (in_valid) begin
               op_sign_reg <= in_data[31];
               op_exp_reg  <= in_data[30:23];
               op_mant_reg <= f_mant(in_data[30:23], in_data[MANT_W-1:0]);
               last_reg    <= in_last;
               // An infinite operand saturates the group at once; the first one sets the sign.
               if (in_data[30:23] == EXP_INF && !acc_inf_reg) begin
                  acc_sign_reg <= in_data[31];
                  acc_exp_reg  <= EXP_INF;
                  acc_mant_reg <= '0;
                  acc_inf_reg  <= 1'b1;
               end
               state_reg <= ST_ALIGN;
            end
            ST_ALIGN: begin
               sum_sign_reg <= add_sign;
               sum_exp_reg  <= add_exp;
               sum_mant_reg <= add_mant;
               state_reg    <= ST_ADD;
            end
            ST_ADD: begin
               norm_first_reg <= 1'b1;
               state_reg      <= ST_NORM;
            end
            ST_NORM: if (norm_done) begin
               acc_sign_reg <= wr_sign;
               acc_exp_reg  <= wr_exp;
               acc_mant_reg <= wr_mant;
               acc_inf_reg  <= wr_inf;
               if (last_reg) begin
                  out_data_reg     <= f_pack(wr_sign, wr_exp, wr_mant);
                  out_valid_reg    <= 1'b1;
                  out_overflow_reg <= wr_inf;
                  state_reg        <= ST_OUT;
               end else begin
                  state_reg <= ST_IDLE;
               end
            end else begin
               sum_exp_reg    <= norm_exp_next;
               sum_mant_reg   <= norm_mant_next;
               norm_first_reg <= 1'b0;
            end
            ST_OUT: if (out_ready) begin
               out_valid_reg <= 1'b0;
               acc_sign_reg  <= 1'b0;
               acc_exp_reg   <= 8'd0;
               acc_mant_reg  <= '0;
               acc_inf_reg   <= 1'b0;
               state_reg     <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_float32_accumulator.sv
// Self-checking bench for float32_accumulator: directed vectors, corner sequences and random groups.
module tb_float32_accumulator;
   import float32_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_overflow;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_acc;
   logic        m_inf;

   always #5 clk = ~clk;

   float32_accumulator dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_overflow (out_overflow)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ovf;
      int          lat_b;
   } vec_t;

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h required %08h", name, got, exp);
      end
   endtask

   // Reference: align with truncation, signed integer sum, then normalise counting left shifts.
   function automatic void model_step(input logic [31:0] acc, input logic acc_inf, input logic [31:0] x,
                                      output logic [31:0] res, output logic res_inf, output int shifts);
      longint ma, mb, mbig, msml, s, mag;
      int     ea, eb, ebig, esml, d, e;
      logic   sbig, ssml, sg;
      res = acc; res_inf = acc_inf; shifts = 0;
      if (acc_inf) return;
      if (x[30:23] == 8'hFF) begin
         res = {x[31], 8'hFF, 23'h0}; res_inf = 1'b1;
         return;
      end
      ea = int'(acc[30:23]); ma = (ea == 0) ? 64'd0 : longint'({1'b1, acc[22:0]});
      eb = int'(x[30:23]);   mb = (eb == 0) ? 64'd0 : longint'({1'b1, x[22:0]});
      if ((ea > eb) || (ea == eb && ma >= mb)) begin
         ebig = ea; mbig = ma; sbig = acc[31]; esml = eb; msml = mb; ssml = x[31];
      end else begin
         ebig = eb; mbig = mb; sbig = x[31]; esml = ea; msml = ma; ssml = acc[31];
      end
      d = ebig - esml;
      msml = (d >= 24) ? 64'd0 : (msml >> d);
      s = (sbig ? -mbig : mbig) + (ssml ? -msml : msml);
      sg = (s < 0);
      mag = sg ? -s : s;
      e = ebig;
      if (mag == 0) begin res = 32'h0; return; end
      if (mag >= 64'h100_0000) begin
         mag = mag >> 1; e++;
         if (e == 255) begin res = {sg, 8'hFF, 23'h0}; res_inf = 1'b1; return; end
      end
      while (mag < 64'h80_0000) begin
         mag = mag << 1; e--; shifts++;
         if (e == 0) begin res = 32'h0; return; end
      end
      res = {sg, 8'(e), mag[22:0]};
   endfunction

   function automatic logic [31:0] rand_op();
      int          r;
      logic        s;
      logic [7:0]  e;
      logic [22:0] f;
      r = int'($urandom_range(0, 19));
      s = 1'($urandom_range(0, 1));
      f = 23'($urandom);
      e = 8'($urandom_range(120, 134));
      if (r == 0) e = 8'h00;
      else if (r == 1) begin e = 8'hFF; f = 23'h0; end
      else if (r == 2) e = 8'($urandom_range(250, 254));
      else if (r == 3) e = 8'($urandom_range(1, 3));
      else if (r <= 6 && m_acc[30:23] != 8'h00 && !m_inf)
         return {~m_acc[31], m_acc[30:8], 8'($urandom)};
      return {s, e, f};
   endfunction

   // Present one operand, wait for acceptance, then count cycles until IDLE or OUT is reached.
   task automatic send(input logic [31:0] d, input logic l, output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      in_data = d; in_last = l; in_valid = 1'b1;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL accept_timeout: in_ready 0 after %0d cycles, required 1", guard);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!(in_ready || out_valid) && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic get_result(output logic [31:0] d, output logic v);
      int guard;
      guard = 0;
      while (!out_valid && guard < 60) begin
         @(posedge clk); #1;
         guard++;
      end
      checks++;
      if (!out_valid) begin
         errors++;
         $display("FAIL out_valid_timeout: out_valid 0, required 1");
      end
      d = out_data; v = out_overflow;
      $display("txn result %08h overflow %0b", d, v);
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      vec_t        vecs[7];
      int          lat, sh, nops;
      logic [31:0] d, x, nacc;
      logic        v, ninf, last;

      vecs[0] = '{32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 3};
      vecs[1] = '{32'h3F800000, 32'hBF400000, 32'h3E800000, 1'b0, 5};
      vecs[2] = '{32'h3FC00000, 32'hBFC00000, 32'h00000000, 1'b0, 3};
      vecs[3] = '{32'h4B800000, 32'h3F800000, 32'h4B800000, 1'b0, 3};
      vecs[4] = '{32'h00000000, 32'hC0400000, 32'hC0400000, 1'b0, 3};
      vecs[5] = '{32'h3F800000, 32'hFF800000, 32'hFF800000, 1'b1, 3};
      vecs[6] = '{32'h00800000, 32'h80800001, 32'h00000000, 1'b0, 4};

      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 32'h0; out_ready = 1'b0;
      m_acc = 32'h0; m_inf = 1'b0;
      #1;
      check32("reset_in_ready", {31'b0, in_ready}, 32'd1);
      check32("reset_out_valid", {31'b0, out_valid}, 32'd0);
      check32("reset_out_data", out_data, 32'h0);
      check32("reset_overflow", {31'b0, out_overflow}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         send(vecs[i].a, 1'b0, lat);
         check32("vec_latency_a", 32'(lat), 32'd3);
         send(vecs[i].b, 1'b1, lat);
         check32("vec_latency_b", 32'(lat), 32'(vecs[i].lat_b));
         get_result(d, v);
         check32("vec_data", d, vecs[i].res);
         check32("vec_overflow", {31'b0, v}, {31'b0, vecs[i].ovf});
      end

      // Overflow, then a stalled output with an operand waiting at the input.
      send(32'h7F7FFFFF, 1'b0, lat);
      send(32'h7F7FFFFF, 1'b1, lat);
      check32("ovf_data", out_data, 32'h7F800000);
      check32("ovf_flag", {31'b0, out_overflow}, 32'd1);
      @(negedge clk);
      in_data = 32'h3F800000; in_last = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check32("stall_data", out_data, 32'h7F800000);
         check32("stall_in_ready", {31'b0, in_ready}, 32'd0);
         check32("stall_out_valid", {31'b0, out_valid}, 32'd1);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check32("release_out_valid", {31'b0, out_valid}, 32'd0);
      check32("release_in_ready", {31'b0, in_ready}, 32'd1);
      send(32'h3F800000, 1'b1, lat);
      get_result(d, v);
      check32("after_ovf_data", d, 32'h3F800000);
      check32("after_ovf_flag", {31'b0, v}, 32'd0);

      // Asynchronous reset while a non-last operand is in NORM.
      send(32'h40400000, 1'b0, lat);
      @(negedge clk);
      in_data = 32'h3F800000; in_last = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check32("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
      check32("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
      check32("async_rst_out_data", out_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      send(32'h40000000, 1'b1, lat);
      get_result(d, v);
      check32("post_rst_data", d, 32'h40000000);

      for (int g = 0; g < 40; g++) begin
         nops = int'($urandom_range(1, 4));
         m_acc = 32'h0; m_inf = 1'b0;
         for (int i = 0; i < nops; i++) begin
            x = rand_op();
            last = (i == nops - 1);
            model_step(m_acc, m_inf, x, nacc, ninf, sh);
            send(x, last, lat);
            check32("rand_latency", 32'(lat), 32'(3 + sh));
            m_acc = nacc; m_inf = ninf;
         end
         get_result(d, v);
         check32("rand_data", d, m_acc);
         check32("rand_overflow", {31'b0, v}, {31'b0, m_inf});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
